// File: rtl/mem_load_unit.sv
// Load unit: accepts one MEM-stage load, issues a word-aligned bus read, waits a
// bounded time for data, and returns the byte/half/word result (sign or zero extended).
module mem_load_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_op,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd,
    output logic        bus_rd_en,
    output logic [31:0] bus_addr,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err
);

    localparam logic [1:0] LS_W = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_B = 2'b10;

    // The timeout fires on the edge that ends the MAX_WAIT-th WAIT cycle.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  op_q, op_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        misaligned;

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  op,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            LS_H:    extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            LS_B:    extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            default: extract = word;
        endcase
    endfunction

    // Byte loads are never misaligned; op 2'b11 behaves as a word load.
    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            LS_H:    misaligned = req_addr[0];
            LS_B:    misaligned = 1'b0;
            default: misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    // NOTE: every next-state variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        bus_addr_d = bus_addr_q;
        off_d      = off_q;
        op_d       = op_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    bus_addr_d = {req_addr[31:2], 2'b00};
                    off_d      = req_addr[1:0];
                    op_d       = req_op;
                    uns_d      = req_unsigned;
                    rd_d       = req_rd;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        data_d  = 32'h0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_d   = 8'h00;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    data_d  = extract(bus_rdata, off_q, op_q, uns_q);
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h01;
                    if (cnt_q == LAST_WAIT) begin
                        err_d   = 1'b1;
                        data_d  = 32'h0;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            bus_addr_q <= 32'h0;
            off_q      <= 2'b00;
            op_q       <= LS_W;
            uns_q      <= 1'b0;
            rd_q       <= 5'd0;
            cnt_q      <= 8'h00;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_addr_q <= bus_addr_d;
            off_q      <= off_d;
            op_q       <= op_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign req_ready  = (state_q == S_IDLE);
    assign bus_rd_en  = (state_q == S_REQ);
    assign resp_valid = (state_q == S_RESP);
    assign bus_addr   = bus_addr_q;
    assign resp_data  = data_q;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: expected responses go into a scoreboard queue
// when a request is issued and are popped when resp_valid appears.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_op;
    logic        req_unsigned;
    logic [4:0]  req_rd;
    logic        bus_rd_en;
    logic [31:0] bus_addr;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb[$];

    mem_load_unit #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_unsigned(req_unsigned),
        .req_rd      (req_rd),
        .bus_rd_en   (bus_rd_en),
        .bus_addr    (bus_addr),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic err);
        exp_t e;
        e.data = d;
        e.rd   = rd;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Presents a request at a negedge; returns in cycle 1 after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [1:0] op, input logic uns,
                         input logic [4:0] rd);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_addr     = a;
        req_op       = op;
        req_unsigned = uns;
        req_rd       = rd;
        tick();
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for resp_valid, checks latency, pops and compares the scoreboard.
    task automatic expect_resp(input string tag, input int lat);
        exp_t e;
        int guard = 0;
        while (resp_valid !== 1'b1 && guard < 300) begin
            tick();
            guard++;
        end
        check({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, resp_data, e.data);
            check({tag, "_rd"}, 32'(resp_rd), 32'(e.rd));
            check({tag, "_err"}, 32'(resp_err), 32'(e.err));
        end
    endtask

    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_resp_valid_off"}, 32'(resp_valid), 32'd0);
        check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    // Aligned load with read data returned k cycles after the strobe.
    task automatic load(input string tag, input logic [31:0] a, input logic [1:0] op,
                        input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                        input int k, input logic [31:0] exp_data);
        push(exp_data, rd, 1'b0);
        issue(a, op, uns, rd);
        check({tag, "_rd_en"}, 32'(bus_rd_en), 32'd1);
        check({tag, "_bus_addr"}, bus_addr, {a[31:2], 2'b00});
        for (int i = 1; i <= k; i++) begin
            tick();
            if (i == 1) check({tag, "_rd_en_single"}, 32'(bus_rd_en), 32'd0);
            if (i == k) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rdata;
            end
        end
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 32'hDEAD_BEEF;
        expect_resp(tag, 2 + k);
    endtask

    initial begin
        logic [31:0] held_data;
        logic [4:0]  held_rd;
        logic        held_err;

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = 32'h0;
        req_op       = 2'b00;
        req_unsigned = 1'b0;
        req_rd       = 5'd0;
        bus_rvalid   = 1'b0;
        bus_rdata    = 32'h0;
        resp_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rd_en", 32'(bus_rd_en), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);

        // Word load, data two cycles after the strobe -> result in cycle 4.
        load("lw", 32'h0000_1004, 2'b00, 1'b0, 5'd5, 32'h8765_4321, 2, 32'h8765_4321);
        release_resp("lw");

        load("lb3",  32'h0000_2003, 2'b10, 1'b0, 5'd6,  32'h80FF_7F01, 1, 32'hFFFF_FF80);
        release_resp("lb3");
        load("lbu3", 32'h0000_2003, 2'b10, 1'b1, 5'd7,  32'h80FF_7F01, 3, 32'h0000_0080);
        release_resp("lbu3");
        load("lb1",  32'h0000_2001, 2'b10, 1'b0, 5'd8,  32'h80FF_7F01, 1, 32'h0000_007F);
        release_resp("lb1");
        load("lb2",  32'h0000_2002, 2'b10, 1'b0, 5'd9,  32'h80FF_7F01, 2, 32'hFFFF_FFFF);
        release_resp("lb2");
        load("lh2",  32'h0000_3002, 2'b01, 1'b0, 5'd10, 32'h8001_1234, 1, 32'hFFFF_8001);
        release_resp("lh2");
        load("lhu2", 32'h0000_3002, 2'b01, 1'b1, 5'd11, 32'h8001_1234, 2, 32'h0000_8001);
        release_resp("lhu2");
        load("lh0",  32'h0000_3000, 2'b01, 1'b0, 5'd12, 32'h8001_1234, 1, 32'h0000_1234);
        release_resp("lh0");
        load("op3w", 32'h0000_4008, 2'b11, 1'b1, 5'd13, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        release_resp("op3w");

        // Misaligned word and half: error in cycle 1, no bus strobe.
        push(32'h0, 5'd14, 1'b1);
        issue(32'h0000_1002, 2'b00, 1'b0, 5'd14);
        check("mis_w_no_rd_en", 32'(bus_rd_en), 32'd0);
        expect_resp("mis_w", 1);
        release_resp("mis_w");

        push(32'h0, 5'd15, 1'b1);
        issue(32'h0000_1001, 2'b01, 1'b0, 5'd15);
        check("mis_h_no_rd_en", 32'(bus_rd_en), 32'd0);
        expect_resp("mis_h", 1);
        release_resp("mis_h");

        // Timeout with MAX_WAIT=4, then a late rvalid in RESP must be ignored.
        push(32'h0, 5'd16, 1'b1);
        issue(32'h0000_5000, 2'b00, 1'b0, 5'd16);
        check("to_rd_en", 32'(bus_rd_en), 32'd1);
        expect_resp("to", 6);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        tick();
        bus_rvalid = 1'b0;
        check("to_late_valid", 32'(resp_valid), 32'd1);
        check("to_late_data", resp_data, 32'h0);
        check("to_late_err", 32'(resp_err), 32'd1);
        release_resp("to");

        // Backpressure: three cycles of resp_ready=0 with a competing request.
        load("bp", 32'h0000_6004, 2'b00, 1'b0, 5'd17, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
        held_data = 32'h0BAD_F00D;
        held_rd   = 5'd17;
        held_err  = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000_7000;
        req_op    = 2'b00;
        req_rd    = 5'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data", resp_data, held_data);
            check("bp_rd", 32'(resp_rd), 32'(held_rd));
            check("bp_err", 32'(resp_err), 32'(held_err));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_no_rd_en", 32'(bus_rd_en), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("bp_idle_after", 32'(req_ready), 32'd1);
        check("bp_not_accepted", 32'(bus_rd_en), 32'd0);
        tick();
        check("bp_still_idle", 32'(bus_rd_en), 32'd0);

        // Reset during WAIT aborts the load; a later rvalid is ignored.
        issue(32'h0000_8004, 2'b00, 1'b0, 5'd21);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("wrst_req_ready", 32'(req_ready), 32'd1);
        check("wrst_rd_en", 32'(bus_rd_en), 32'd0);
        check("wrst_bus_addr", bus_addr, 32'h0);
        check("wrst_resp_valid", 32'(resp_valid), 32'd0);
        check("wrst_resp_data", resp_data, 32'h0);
        check("wrst_resp_rd", 32'(resp_rd), 32'd0);
        check("wrst_resp_err", 32'(resp_err), 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        tick();
        bus_rvalid = 1'b0;
        tick();
        check("wrst_ignore_valid", 32'(resp_valid), 32'd0);
        check("wrst_ignore_data", resp_data, 32'h0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
